// File: rtl/des_key_schedule.sv
// des_key_schedule
//   Iterative DES key schedule. It loads a post-PC-1 key and then presents
//   one 48-bit round subkey per accepted handshake. The order is K1..K16
//   for encryption and K16..K1 for decryption. The C/D halves are held in
//   registers, and PC-2 is applied combinationally on the way out.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load request (honoured only in IDLE)
//   key_in[55:0] post-PC-1 key, [55:28] = C0, [27:0] = D0
//   decrypt      sampled with start; 1 = reverse subkey order
//   busy         sequence in progress (drops with the done pulse)
//   sk_valid     sk_out holds a subkey
//   sk_ready     consumer accepts on sk_valid && sk_ready
//   sk_out[47:0] PC-2(C,D); bit 47 = PC-2 output bit 1
//   sk_round     subkey number minus 1 (K1 -> 0, K16 -> 15)
//   sk_last      marks the 16th subkey of the sequence
//   done         one-cycle pulse after the 16th subkey is accepted
module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [55:0] key_in,
   input  logic        decrypt,
   output logic        busy,
   output logic        sk_valid,
   input  logic        sk_ready,
   output logic [47:0] sk_out,
   output logic [3:0]  sk_round,
   output logic        sk_last,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // PC-2 selection, 1-based positions into the 56-bit C||D (bit 1 = MSB of C)
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   state_t      state;
   logic [27:0] c, d;
   logic [3:0]  step;
   logic        dec;
   logic        by1;
   logic [55:0] cd;

   function automatic logic [27:0] rot(input logic [27:0] x, input logic right,
                                       input logic one);
      logic [27:0] r;
      case ({right, one})
         2'b01:   r = {x[26:0], x[27]};
         2'b00:   r = {x[25:0], x[27:26]};
         2'b11:   r = {x[0], x[27:1]};
         default: r = {x[1:0], x[27:2]};
      endcase
      return r;
   endfunction

   // The encrypt step s uses round s+2 and the decrypt step s uses round 16-s.
   // Both index into the same 1-position entries when s is 0, 7 or 14.
   assign by1 = (step == 4'd0) || (step == 4'd7) || (step == 4'd14);

   assign cd = {c, d};
   for (genvar i = 0; i < 48; i++) begin : g_pc2
      assign sk_out[47-i] = cd[56-PC2[i]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         c        <= '0;
         d        <= '0;
         step     <= '0;
         dec      <= 1'b0;
         busy     <= 1'b0;
         sk_valid <= 1'b0;
         sk_round <= '0;
         sk_last  <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // The total shift over 16 rounds is 28, so the unrotated key is already the K16 state.
                  dec      <= decrypt;
                  c        <= decrypt ? key_in[55:28] : rot(key_in[55:28], 1'b0, 1'b1);
                  d        <= decrypt ? key_in[27:0]  : rot(key_in[27:0],  1'b0, 1'b1);
                  step     <= '0;
                  state    <= RUN;
                  busy     <= 1'b1;
                  sk_valid <= 1'b1;
                  sk_round <= decrypt ? 4'd15 : 4'd0;
                  sk_last  <= 1'b0;
               end
            end
            RUN: begin
               if (sk_ready) begin
                  if (step == 4'd15) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     sk_valid <= 1'b0;
                     sk_last  <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     c        <= rot(c, dec, by1);
                     d        <= rot(d, dec, by1);
                     step     <= step + 4'd1;
                     sk_round <= dec ? (4'd14 - step) : (step + 4'd1);
                     sk_last  <= (step == 4'd14);
                  end
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator. Sits directly upstream of the DES round datapath (`encrypt`) and feeds it one 48-bit round subkey per round. It accepts a 56-bit post-PC-1 key and produces subkeys K1..K16 in order for encryption, or K16..K1 for decryption. Subkeys are delivered over a valid/ready handshake so the round stage can stall. The C/D rotation state is registered, and the FIPS 46-3 PC-2 compression is applied combinationally on the output.

## Interface
Parameters:
- None. All widths are fixed by DES: key 56, subkey 48, round index 4.

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  load request; sampled only in IDLE.
- `key_in`  input  56  post-PC-1 key; [55:28] = C0, [27:0] = D0.
- `decrypt`  input  1  sampled with `start`; 1 selects reverse subkey order.
- `busy`  output  1  high from the cycle after `start` is accepted until the last subkey is accepted.
- `sk_valid`  output  1  `sk_out` holds a valid subkey.
- `sk_ready`  input  1  consumer accepts the subkey when `sk_valid && sk_ready`.
- `sk_out`  output  48  PC-2(C,D) of the current state; bit 47 = PC-2 output bit 1.
- `sk_round`  output  4  index of the presented subkey minus 1 (K1 → 0, K16 → 15).
- `sk_last`  output  1  high with the 16th subkey of the sequence.
- `done`  output  1  one-cycle pulse in the cycle after the 16th subkey is accepted.

## Operation
- Reset values: state IDLE; C = D = 0; step counter = 0; `busy`, `sk_valid`, `sk_last`, `done` = 0; `sk_round` = 0. `sk_out` = PC-2(0,0) = 0.
- Shift schedule, encryption rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- FSM states:
  - IDLE: on `start`, load C/D and go to RUN; step = 0.
    - `decrypt` = 0: load C = rotl(C0,1), D = rotl(D0,1), i.e. the K1 state.
    - `decrypt` = 1: load C0/D0 unrotated, i.e. the K16 state, since the total shift is 28.
  - RUN: `sk_valid` = 1. On handshake with step < 15: step += 1 and C/D advance.
    - Encrypt: rotl by the schedule entry for round step+2.
    - Decrypt: rotr by the schedule entry for encryption round 16−step.
    - The decrypt rotr sequence is therefore 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - On handshake with step = 15, go to DONE.
  - DONE: `done` = 1 for one cycle, `sk_valid` = 0, then IDLE.
- `sk_round` = step for encrypt and 15−step for decrypt. `sk_last` = (step == 15) in RUN.
- Rotations are 28-bit circular, applied to C and D independently. Each rotation is 1 or 2 positions; no other amounts occur.
- `start` outside IDLE (RUN or DONE) is ignored. `key_in` and `decrypt` are not retained beyond the load cycle.
- Stall: while `sk_valid && !sk_ready`, C, D, step, `sk_out`, `sk_round` and `sk_last` hold unchanged.
- Reset asserted mid-sequence returns the block to IDLE immediately; the partial sequence is discarded.

## Timing
- `start` accepted at edge T: `busy` and `sk_valid` are high from T+1, with the first subkey valid on `sk_out` at T+1.
- Throughput: one subkey per cycle when `sk_ready` is held high. With continuous ready, K16 (or K1 in decrypt) is presented at T+16 and `done` pulses at T+17.
- `busy` falls in the same cycle `done` pulses. The earliest next `start` is accepted at the edge after `done` (IDLE), so back-to-back sequences have a 2-cycle gap.
- `sk_out` is combinational from registers only. There is no input-to-output combinational path; `sk_ready` affects state only.

## Test plan
- Reset: assert `rst_n` = 0 mid-RUN (step 7) → `sk_valid`, `busy`, `done` = 0 asynchronously. A subsequent `start` restarts at K1.
- Encrypt, FIPS vector: `key_in` = 56'hF0CCAAF556678F, `decrypt` = 0, `sk_ready` = 1.
  - Required: `sk_out` = 48'h1B02EFFC7072 with `sk_round` = 0 at T+1.
  - Required: `sk_out` = 48'hCB3D8B0E17F5 with `sk_round` = 15 and `sk_last` = 1 at T+16.
  - Required: `done` at T+17.
- Decrypt, same key: first `sk_out` = 48'hCB3D8B0E17F5 (`sk_round` = 15); 16th `sk_out` = 48'h1B02EFFC7072 (`sk_round` = 0). Every intermediate subkey matches the encrypt run in reverse.
- Backpressure: random `sk_ready` at 30% duty → the same 16-subkey sequence is produced, with `sk_out` stable during every stall and each subkey accepted exactly once.
- Start while busy: pulse `start` with a different key at step 5 and at the `done` cycle → both ignored, sequence unchanged. `start` one cycle after `done` is accepted.
- Round-trip: 100 random 56-bit keys; encrypt sequence = reversed decrypt sequence, checked against a reference model.
